// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell, LSB first, one bit per clock.
// Valid/ready handshake on both the operand side and the result side.
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   in_valid / in_ready  operand handshake (in_ready high only in IDLE)
//   a, b, cin            operands, sampled only on the accept edge
//   out_valid/out_ready  result handshake (out_valid high only in DONE)
//   sum, cout            registered a+b+cin, held after handoff
//   ovf                  signed overflow, only with SERIAL_ADDER_OVF_EN

module fa_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic             fa_s;
    logic             fa_c;
    logic [WIDTH-1:0] res_nxt;

    fa_cell u_fa (
        .a_i (a_sh_q[0]),
        .b_i (b_sh_q[0]),
        .c_i (carry_q),
        .s_o (fa_s),
        .c_o (fa_c)
    );

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 lands at LSB.
    generate
        if (WIDTH == 1) begin : g_res1
            assign res_nxt = fa_s;
        end else begin : g_resn
            assign res_nxt = {fa_s, res_q[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                carry_d = fa_c;
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                res_d   = res_nxt;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    sum_d   = res_nxt;
                    cout_d  = fa_c;
`ifdef SERIAL_ADDER_OVF_EN
                    // carry_q is the carry into the MSB on the last bit
                    ovf_d   = carry_q ^ fa_c;
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8).
// Hand-computed vectors, latency, backpressure, back-to-back, reset.

module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;
`endif

    int nvec;
    int nerr;
    int cyc;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf       (ovf),
`endif
        .cout      (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called one step after an edge with the DUT in IDLE.
    task automatic run_op(input logic [7:0] ta,
                          input logic [7:0] tb2,
                          input logic       tc,
                          input logic [7:0] es,
                          input logic       ec,
                          input logic       eo);
        int n;
        check("rdy_idle", in_ready, 1);
        a = ta;
        b = tb2;
        cin = tc;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = 8'h00;
        b = 8'h00;
        cin = 1'b0;
        check("rdy_run", in_ready, 0);
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        check("latency", n, WIDTH);
        check("sum", sum, es);
        check("cout", cout, ec);
`ifdef SERIAL_ADDER_OVF_EN
        check("ovf", ovf, eo);
`else
        if (eo) begin
        end
`endif
    endtask

    // DONE with out_ready high: one edge back to IDLE, result held.
    task automatic drain(input logic [7:0] es);
        tick();
        check("idle_rdy", in_ready, 1);
        check("idle_ov", out_valid, 0);
        check("sum_held", sum, es);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        logic [7:0] s;
        logic       co;
    } vec_t;

    vec_t b2b[4];
    int   tacc[4];

    initial begin
        int n;
        nvec = 0;
        nerr = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        out_ready = 1'b1;

        b2b[0] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
        b2b[1] = '{8'h64, 8'h32, 1'b0, 8'h96, 1'b0};
        b2b[2] = '{8'h99, 8'h88, 1'b1, 8'h22, 1'b1};
        b2b[3] = '{8'h37, 8'h2C, 1'b1, 8'h64, 1'b0};

        repeat (3) tick();
        check("rst_rdy", in_ready, 1);
        check("rst_ov", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        rst_n = 1'b1;
        tick();

        run_op(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b0);
        drain(8'h96);
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        drain(8'h00);
        run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
        drain(8'hFF);
        run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        drain(8'h80);
        run_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
        drain(8'h00);
        run_op(8'h01, 8'hFF, 1'b0, 8'h00, 1'b1, 1'b0);
        drain(8'h00);

        // Backpressure: hold the result for 5 clocks.
        out_ready = 1'b0;
        run_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_ov", out_valid, 1);
            check("bp_rdy", in_ready, 0);
            check("bp_sum", sum, 8'h46);
            check("bp_cout", cout, 0);
        end
        out_ready = 1'b1;
        drain(8'h46);

        // Back-to-back with in_valid held high.
        a = b2b[0].a;
        b = b2b[0].b;
        cin = b2b[0].c;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (!in_ready && n < 40) begin
                tick();
                n++;
            end
            check("b2b_rdy", in_ready, 1);
            tacc[i] = cyc;
            tick();
            if (i < 3) begin
                a = b2b[i+1].a;
                b = b2b[i+1].b;
                cin = b2b[i+1].c;
            end else begin
                in_valid = 1'b0;
            end
            n = 0;
            while (!out_valid && n < 40) begin
                tick();
                n++;
            end
            check("b2b_lat", n, WIDTH);
            check("b2b_sum", sum, b2b[i].s);
            check("b2b_cout", cout, b2b[i].co);
            if (i > 0) begin
                check("b2b_gap", tacc[i] - tacc[i-1], WIDTH + 2);
            end
        end
        drain(8'h64);

        // Reset in the middle of RUN (cnt == 3).
        a = 8'h11;
        b = 8'h22;
        cin = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        check("mid_busy", in_ready, 0);
        rst_n = 1'b0;
        #1;
        check("mr_rdy", in_ready, 1);
        check("mr_sum", sum, 0);
        check("mr_cout", cout, 0);
        check("mr_ov", out_valid, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("rel_rdy", in_ready, 1);
        check("rel_ov", out_valid, 0);
        check("rel_sum", sum, 0);
        run_op(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);
        drain(8'h30);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

endmodule
